// File: rtl/conversor_bin_bcd_seq_if.sv
// conversor_bin_bcd_seq_if: start/busy/done handshake and data path of the BCD converter.
interface conversor_bin_bcd_seq_if #(parameter int LARGURA = 8, parameter int DIGITOS = 3);
  logic inicio;
  logic [LARGURA-1:0] entrada;
  logic ocupado;
  logic pronto;
  logic [4*DIGITOS-1:0] bcd;
  modport master(output inicio, entrada, input ocupado, pronto, bcd);
  modport slave(input inicio, entrada, output ocupado, pronto, bcd);
endinterface

// File: rtl/conversor_bin_bcd_seq.sv
// conversor_bin_bcd_seq: double-dabble binary to BCD, one bit per clock.
module conversor_bin_bcd_seq #(
  parameter int LARGURA = 8,
  parameter int DIGITOS = 3
) (
  input logic clk,
  input logic reset,
  conversor_bin_bcd_seq_if.slave bus
);
  localparam int CW = $clog2(LARGURA + 1);
  typedef enum logic {OCIOSO, CONVERTE} estado_t;
  estado_t r_estado, w_prox;
  logic [LARGURA-1:0] r_bin_sr;
  logic [4*DIGITOS-1:0] r_bcd_sr, r_bcd, w_adj, w_bcd_nxt;
  logic [CW-1:0] r_cnt;
  logic r_pronto, w_aceita, w_ultimo;
  for (genvar g = 0; g < DIGITOS; g++) begin : g_adj
    assign w_adj[4*g +: 4] = (r_bcd_sr[4*g +: 4] >= 4'd5) ? r_bcd_sr[4*g +: 4] + 4'd3 : r_bcd_sr[4*g +: 4];
  end
  // adjusted digits shifted left, taking the next binary MSB into the units digit
  assign w_bcd_nxt = {w_adj[4*DIGITOS-2:0], r_bin_sr[LARGURA-1]};
  always_comb begin
    w_aceita = (r_estado == OCIOSO) && bus.inicio;
    w_ultimo = (r_estado == CONVERTE) && (r_cnt == CW'(1));
    w_prox = w_aceita ? CONVERTE : w_ultimo ? OCIOSO : r_estado;
  end
  always_ff @(posedge clk)
    if (reset) r_estado <= OCIOSO;
    else r_estado <= w_prox;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_bin_sr <= '0;
      r_bcd_sr <= '0;
      r_cnt <= '0;
      r_bcd <= '0;
      r_pronto <= 1'b0;
    end else begin
      r_pronto <= w_ultimo;
      if (w_aceita) begin
        r_bin_sr <= bus.entrada;
        r_bcd_sr <= '0;
        r_cnt <= CW'(LARGURA);
      end else if (r_estado == CONVERTE) begin
        r_bcd_sr <= w_bcd_nxt;
        r_bin_sr <= {r_bin_sr[LARGURA-2:0], 1'b0};
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_ultimo) r_bcd <= w_bcd_nxt;
    end
  end
  assign bus.ocupado = (r_estado != OCIOSO);
  assign bus.pronto = r_pronto;
  assign bus.bcd = r_bcd;
endmodule

// File: tb/tb_conversor_bin_bcd_seq.sv
// tb_conversor_bin_bcd_seq: directed scoreboard bench for the sequential BCD converter.
module tb_conversor_bin_bcd_seq;
  logic clk = 1'b0;
  logic reset;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int n_pronto = 0;
  int t_ini = 0;
  logic [11:0] q[$];
  conversor_bin_bcd_seq_if #(.LARGURA(8), .DIGITOS(3)) ifc();
  conversor_bin_bcd_seq #(.LARGURA(8), .DIGITOS(3)) dut(.clk(clk), .reset(reset), .bus(ifc.slave));
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;
  function automatic logic [11:0] to_bcd(int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  always @(negedge clk)
    if (!reset && ifc.pronto) begin
      n_pronto++;
      chk("sb_nonempty", 32'(q.size() != 0), 1);
      if (q.size() != 0) chk("bcd", 32'(ifc.bcd), 32'(q.pop_front()));
    end
  always @(negedge clk)
    if (ifc.ocupado)
      for (int d = 0; d < 3; d++) chk("digit_le9", 32'(dut.r_bcd_sr[4*d +: 4] > 4'd9), 0);
  task automatic alinha();
    @(posedge clk);
    #1;
  endtask
  task automatic start(int v);
    ifc.inicio = 1'b1;
    ifc.entrada = 8'(v);
    q.push_back(to_bcd(v));
    alinha();
    t_ini = cyc;
    ifc.inicio = 1'b0;
  endtask
  task automatic wait_pronto();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ifc.pronto && k < 20);
    chk("pronto_seen", 32'(ifc.pronto), 1);
  endtask
  initial begin
    int hi;
    int np;
    int c1;
    reset = 1'b1;
    ifc.inicio = 1'b0;
    ifc.entrada = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ocupado", 32'(ifc.ocupado), 0);
    chk("rst_pronto", 32'(ifc.pronto), 0);
    chk("rst_bcd", 32'(ifc.bcd), 0);
    alinha();
    np = n_pronto;
    hi = 0;
    start(255);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      hi += int'(ifc.ocupado);
    end
    chk("ocupado_cycles", hi, 8);
    chk("pronto_once", n_pronto - np, 1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bcd_hold", 32'(ifc.bcd), 32'h255);
    end
    alinha();
    for (int v = 0; v < 256; v++) begin
      start(v);
      wait_pronto();
      chk("latency", cyc - t_ini, 8);
      chk("ocupado_done", 32'(ifc.ocupado), 0);
      alinha();
    end
    start(128);
    wait_pronto();
    c1 = cyc;
    chk("b2b_first", 32'(ifc.bcd), 32'h128);
    ifc.inicio = 1'b1;
    ifc.entrada = 8'd37;
    q.push_back(to_bcd(37));
    alinha();
    ifc.inicio = 1'b0;
    chk("b2b_ocupado", 32'(ifc.ocupado), 1);
    chk("b2b_pronto_fall", 32'(ifc.pronto), 0);
    wait_pronto();
    chk("b2b_spacing", cyc - c1, 9);
    chk("b2b_second", 32'(ifc.bcd), 32'h037);
    alinha();
    np = n_pronto;
    start(200);
    repeat (2) alinha();
    ifc.inicio = 1'b1;
    ifc.entrada = 8'd5;
    alinha();
    ifc.inicio = 1'b0;
    wait_pronto();
    chk("busy_latency", cyc - t_ini, 8);
    chk("busy_ocupado", 32'(ifc.ocupado), 0);
    repeat (12) @(negedge clk);
    chk("busy_one_pronto", n_pronto - np, 1);
    chk("busy_bcd", 32'(ifc.bcd), 32'h200);
    alinha();
    np = n_pronto;
    start(255);
    repeat (3) alinha();
    reset = 1'b1;
    alinha();
    reset = 1'b0;
    q.delete();
    chk("midrst_ocupado", 32'(ifc.ocupado), 0);
    chk("midrst_pronto", 32'(ifc.pronto), 0);
    chk("midrst_bcd", 32'(ifc.bcd), 0);
    repeat (12) @(negedge clk);
    chk("midrst_no_pronto", n_pronto - np, 0);
    chk("midrst_bcd_kept", 32'(ifc.bcd), 0);
    alinha();
    start(42);
    wait_pronto();
    chk("after_rst_latency", cyc - t_ini, 8);
    chk("after_rst_bcd", 32'(ifc.bcd), 32'h042);
    alinha();
    start(5);
    wait_pronto();
    chk("adj5", 32'(ifc.bcd), 32'h005);
    alinha();
    start(50);
    wait_pronto();
    chk("adj50", 32'(ifc.bcd), 32'h050);
    alinha();
    repeat (3) alinha();
    chk("sb_drained", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/conversor_bin_bcd_seq.md
# conversor_bin_bcd_seq

Sequential binary-to-BCD converter for the display path. It runs the shift-and-add-3 (double-dabble) algorithm one bit per clock and applies the per-digit "≥ 5 → add 3" adjustment to every BCD digit each step. A start/busy/done handshake connects it to the control logic that feeds the 7-segment decoders. It owns the sequencing, the bit counter, and the scratch register of the BCD adjust datapath.

## Interface
- LARGURA, 8: width of the binary input; must satisfy 10^DIGITOS > 2^LARGURA − 1.
- DIGITOS, 3: number of BCD output digits; the output is 4·DIGITOS bits wide.

- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- inicio  in  1  start request; sampled only in state OCIOSO.
- entrada  in  LARGURA  binary value; captured on the edge that accepts inicio.
- ocupado  out  1  high while a conversion is in progress.
- pronto  out  1  one-cycle pulse when bcd has just been updated.
- bcd  out  4·DIGITOS  result; digit i is bcd[4i+3:4i], digit 0 is the units digit. Held between conversions.

## Operation
- States: OCIOSO, CONVERTE.
- Registers:
  - bin_sr (LARGURA bits)
  - bcd_sr (4·DIGITOS bits)
  - cnt (ceil(log2(LARGURA+1)) bits)
  - bcd output register
  - pronto register
- OCIOSO with inicio=1:
  - bin_sr←entrada, bcd_sr←0, cnt←LARGURA.
  - Go to CONVERTE. ocupado=1 from the next cycle.
- OCIOSO with inicio=0: hold all state.
- CONVERTE, one step per cycle:
  - For each digit d of bcd_sr: d' = d+3 if d ≥ 5 (d ∈ 5..9), else d. The add is 4-bit; because d ≤ 9, the result never exceeds 12.
  - {bcd_sr, bin_sr} ← {adjusted bcd_sr, bin_sr} shifted left by 1. The MSB of bin_sr enters bit 0 of digit 0, and zero enters the LSB of bin_sr.
  - cnt ← cnt−1.
- Last step (cnt=1 before the edge):
  - bcd ← the new shifted value (the adjusted-and-shifted result, not the pre-step bcd_sr).
  - pronto←1, go to OCIOSO.
- inicio while in CONVERTE: ignored, not queued. entrada changes during conversion have no effect.
- pronto is deasserted on every edge where it is not explicitly set.
- Reset, at any time including mid-conversion:
  - State OCIOSO; ocupado=0, pronto=0, bcd=0, bcd_sr=0, bin_sr=0, cnt=0.
  - A conversion interrupted by reset is discarded; bcd stays 0.
- Every output digit is in 0..9 for any entrada in 0..2^LARGURA−1.

## Timing
- Edge e0 accepts inicio. Shift steps occur on edges e1..eLARGURA.
- ocupado is high in the cycles after e0 through the cycle ending at eLARGURA (LARGURA cycles).
- After eLARGURA: bcd is valid, pronto=1 for exactly one cycle, ocupado=0.
- Latency from the accepting edge to a valid bcd is LARGURA clocks; the default is 8.
- Back-to-back operation: inicio=1 during the pronto cycle is accepted at that cycle's edge. pronto falls and ocupado rises on that same edge. Throughput is one conversion per LARGURA+1 cycles.
- bcd changes only on a completing edge or on reset.
- ocupado is derived from state (state ≠ OCIOSO) with no combinational path from inputs. pronto is registered.

## Test plan
- Reset, then entrada=255 with inicio pulsed for one cycle:
  - ocupado high for 8 cycles.
  - pronto pulses once.
  - bcd=0x255 (digits 2,5,5).
  - bcd is held for ≥5 following idle cycles.
- Sweep entrada 0..255, each followed by waiting for pronto:
  - bcd matches the decimal digits of entrada in every case (e.g. 0→0x000, 9→0x009, 10→0x010, 99→0x099, 100→0x100, 128→0x128).
- Back-to-back: convert 128, then assert inicio with entrada=37 in the pronto cycle.
  - Second pronto arrives exactly 9 cycles after the first.
  - bcd=0x128, then 0x037.
- Start while busy: convert 200 and pulse inicio with entrada=5 at step 3.
  - Only one pronto.
  - bcd=0x200.
  - ocupado drops on schedule.
- Reset mid-conversion: start 255 and assert reset for one cycle after step 4.
  - ocupado=0, pronto=0, bcd=0 after that edge.
  - No pronto follows.
  - A new conversion of 42 then yields 0x042 with normal latency.
- Adjust boundary: entrada=5, then entrada=50.
  - Results are 0x005 and 0x050.
  - Internal bcd_sr digits are never > 9 after any adjust step (checked by assertion).
